// File: rtl/spi_slave_sync.sv
// Oversampled SPI slave: synchronised SCLK/CS/MOSI, RX FIFO, TX holding register with echo fallback.
// Optional sticky overrun/underrun flags with SPI_SLAVE_ERR_FLAGS_EN.
module spi_slave_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned RX_DEPTH    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  ,
  output logic             ovr_err,
  output logic             udr_err,
  input  logic             err_clr
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned AW    = $clog2(RX_DEPTH);
  localparam int unsigned PW    = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_d1_q, cs_d1_q;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-2:0]       rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
  logic                   skip_q, skip_d;
  logic                   word_done_q, word_done_d;
  logic [WIDTH-1:0]       last_rx_q, last_rx_d;
  logic [WIDTH-1:0]       hold_q, hold_d;
  logic                   hold_empty_q, hold_empty_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]       mem_q [RX_DEPTH];
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   busy_q, busy_d, miso_q, miso_d;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic                   ovr_q, ovr_d, udr_q, udr_d;
`endif

  logic sclk_s, cs_s, mosi_s;
  logic rise_c, fall_c, lead_c, trail_c, sample_c, shift_c;
  logic cs_fall_c, active_c, load_c, use_hold_c, word_end_c;
  logic full_c, pop_c, do_push_c;
  logic [WIDTH-1:0] rx_word_c;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Edge classification from the synchronised SCLK
  assign rise_c    = sclk_s & ~sclk_d1_q;
  assign fall_c    = ~sclk_s & sclk_d1_q;
  assign lead_c    = CPOL ? fall_c : rise_c;
  assign trail_c   = CPOL ? rise_c : fall_c;
  assign sample_c  = CPHA ? trail_c : lead_c;
  assign shift_c   = CPHA ? lead_c : trail_c;
  assign cs_fall_c = cs_d1_q & ~cs_s;

  assign active_c   = (state_q == ST_SHIFT) & ~cs_s;
  assign load_c     = ~cs_s & ((state_q == ST_LOAD) | ((state_q == ST_SHIFT) & word_done_q));
  assign use_hold_c = load_c & ~hold_empty_q;
  assign word_end_c = active_c & sample_c & (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign rx_word_c  = {rx_shift_q, mosi_s};

  assign full_c    = (wr_ptr_q - rd_ptr_q) == PW'(RX_DEPTH);
  assign pop_c     = rx_valid_q & rx_ready;
  assign do_push_c = word_end_c & (~full_c | pop_c);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    skip_d       = skip_q;
    word_done_d  = word_end_c;
    last_rx_d    = last_rx_q;
    hold_d       = hold_q;
    hold_empty_d = hold_empty_q;
    wr_ptr_d     = wr_ptr_q + PW'(do_push_c);
    rd_ptr_d     = rd_ptr_q + PW'(pop_c);
    rx_valid_d   = 1'b0;
    rx_data_d    = rx_data_q;
    busy_d       = ~cs_s;
    miso_d       = 1'b0;

    case (state_q)
      ST_IDLE:  if (cs_fall_c) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: state_d = ST_SHIFT;
      default:  state_d = ST_IDLE;
    endcase
    if (cs_s) state_d = ST_IDLE;

    if (cs_s) begin
      bit_cnt_d = '0;
    end else if (active_c & sample_c) begin
      bit_cnt_d  = word_end_c ? '0 : bit_cnt_q + CNT_W'(1);
      rx_shift_d = rx_word_c[WIDTH-2:0];
    end
    if (word_end_c) last_rx_d = rx_word_c;

    // A freshly loaded word keeps its MSB until the first edge after the load has passed
    if (load_c) begin
      tx_shift_d = use_hold_c ? hold_q : last_rx_q;
      skip_d     = 1'b1;
    end else if (active_c & shift_c) begin
      if (!skip_q) tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
      skip_d = 1'b0;
    end else if (active_c & sample_c) begin
      skip_d = 1'b0;
    end

    if (use_hold_c) begin
      hold_empty_d = 1'b1;
    end else if (tx_valid & hold_empty_q) begin
      hold_d       = tx_data;
      hold_empty_d = 1'b0;
    end

    rx_valid_d = (wr_ptr_d != rd_ptr_d);
    if (do_push_c && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) rx_data_d = rx_word_c;
    else                                                   rx_data_d = mem_q[rd_ptr_d[AW-1:0]];

    miso_d = ~cs_s & tx_shift_d[WIDTH-1];

`ifdef SPI_SLAVE_ERR_FLAGS_EN
    ovr_d = err_clr ? 1'b0 : ovr_q;
    udr_d = err_clr ? 1'b0 : udr_q;
    if (word_end_c & full_c & ~pop_c) ovr_d = 1'b1;
    if (load_c & hold_empty_q)        udr_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q  <= {SYNC_STAGES{CPOL}};
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_d1_q    <= CPOL;
      cs_d1_q      <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      skip_q       <= 1'b0;
      word_done_q  <= 1'b0;
      last_rx_q    <= '0;
      hold_q       <= '0;
      hold_empty_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      miso_q       <= 1'b0;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
      ovr_q        <= 1'b0;
      udr_q        <= 1'b0;
`endif
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_d1_q    <= sclk_s;
      cs_d1_q      <= cs_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      skip_q       <= skip_d;
      word_done_q  <= word_done_d;
      last_rx_q    <= last_rx_d;
      hold_q       <= hold_d;
      hold_empty_q <= hold_empty_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      busy_q       <= busy_d;
      miso_q       <= miso_d;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
      ovr_q        <= ovr_d;
      udr_q        <= udr_d;
`endif
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q[AW-1:0]] <= rx_word_c;
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = busy_q;
  assign busy        = busy_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = hold_empty_q;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  assign ovr_err     = ovr_q;
  assign udr_err     = udr_q;
`endif

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: mode 0 / 8-bit and mode 3 / 16-bit instances driven by a bit-banged master.
module tb_spi_slave_sync;

  localparam int HC = 10;

  logic clk = 1'b0;
  logic rst;
  logic mosi;
  logic sclk0, cs0_n, miso0, miso_oe0, rx_valid0, rx_ready0, tx_valid0, tx_ready0, busy0;
  logic [7:0] rx_data0, tx_data0;
  logic sclk1, cs1_n, miso1, miso_oe1, rx_valid1, rx_ready1, tx_valid1, tx_ready1, busy1;
  logic [15:0] rx_data1, tx_data1;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
  logic ovr0, udr0, ovr1, udr1, err_clr;
`endif

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] mon_e0, mon_e1, d;

  always #5 clk = ~clk;

  spi_slave_sync #(.WIDTH(8), .RX_DEPTH(4), .SYNC_STAGES(2), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .rst(rst), .spi_sclk(sclk0), .spi_cs_n(cs0_n), .spi_mosi(mosi),
    .spi_miso(miso0), .spi_miso_oe(miso_oe0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_ready(rx_ready0), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
    .busy(busy0)
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    , .ovr_err(ovr0), .udr_err(udr0), .err_clr(err_clr)
`endif
  );

  spi_slave_sync #(.WIDTH(16), .RX_DEPTH(4), .SYNC_STAGES(2), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .spi_sclk(sclk1), .spi_cs_n(cs1_n), .spi_mosi(mosi),
    .spi_miso(miso1), .spi_miso_oe(miso_oe1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_ready(rx_ready1), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .busy(busy1)
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    , .ovr_err(ovr1), .udr_err(udr1), .err_clr(err_clr)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_h();
    repeat (HC) @(negedge clk);
  endtask

  task automatic frame_begin(input int sel);
    if (sel == 0) cs0_n = 1'b0; else cs1_n = 1'b0;
    wait_h();
  endtask

  task automatic frame_end(input int sel);
    wait_h();
    if (sel == 0) cs0_n = 1'b1; else cs1_n = 1'b1;
    repeat (2 * HC) @(negedge clk);
  endtask

  // Mode 0 master: data set while SCLK low, sampled on rising; mode 3: set on falling, sampled on rising
  task automatic spi_word(input int sel, input int nbits, input logic [15:0] dout, output logic [15:0] din);
    din = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (sel == 0) begin
        mosi = dout[i];
        wait_h();
        din   = {din[14:0], miso0};
        sclk0 = 1'b1;
        wait_h();
        sclk0 = 1'b0;
      end else begin
        sclk1 = 1'b0;
        mosi  = dout[i];
        wait_h();
        din   = {din[14:0], miso1};
        sclk1 = 1'b1;
        wait_h();
      end
    end
  endtask

  task automatic load_tx(input int sel, input logic [15:0] data);
    if (sel == 0) begin tx_data0 = data[7:0]; tx_valid0 = 1'b1; end
    else          begin tx_data1 = data;      tx_valid1 = 1'b1; end
    @(negedge clk);
    tx_valid0 = 1'b0;
    tx_valid1 = 1'b0;
    check_eq("tx_ready_low", 32'(sel == 0 ? tx_ready0 : tx_ready1), 32'(0));
  endtask

  // Scoreboard: compare every FIFO pop against the oldest word sent
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && rx_valid0 && rx_ready0) begin
        mon_e0 = (q0.size() > 0) ? q0.pop_front() : ~{8'h00, rx_data0};
        check_eq("rx0", 32'(rx_data0), 32'(mon_e0));
      end
      if (!rst && rx_valid1 && rx_ready1) begin
        mon_e1 = (q1.size() > 0) ? q1.pop_front() : ~rx_data1;
        check_eq("rx1", 32'(rx_data1), 32'(mon_e1));
      end
    end
  end

  initial begin
    rst = 1'b1; mosi = 1'b0;
    sclk0 = 1'b0; cs0_n = 1'b1; rx_ready0 = 1'b1; tx_valid0 = 1'b0; tx_data0 = '0;
    sclk1 = 1'b1; cs1_n = 1'b1; rx_ready1 = 1'b1; tx_valid1 = 1'b0; tx_data1 = '0;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    repeat (4) @(negedge clk);
    check_eq("rst_busy", 32'(busy0), 32'(0));
    check_eq("rst_oe", 32'(miso_oe0), 32'(0));
    check_eq("rst_miso", 32'(miso0), 32'(0));
    check_eq("rst_rx_valid", 32'(rx_valid0), 32'(0));
    check_eq("rst_rx_data", 32'(rx_data0), 32'(0));
    check_eq("rst_tx_ready", 32'(tx_ready0), 32'(1));
    check_eq("rst_tx_ready1", 32'(tx_ready1), 32'(1));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Echo fallback with no TX word queued
    frame_begin(0);
    check_eq("busy_in_frame", 32'(busy0), 32'(1));
    check_eq("oe_in_frame", 32'(miso_oe0), 32'(1));
    q0.push_back(16'h5A); spi_word(0, 8, 16'h5A, d); check_eq("echo_first", 32'(d), 32'h00);
    q0.push_back(16'h81); spi_word(0, 8, 16'h81, d); check_eq("echo_second", 32'(d), 32'h5A);
    frame_end(0);
    check_eq("busy_idle", 32'(busy0), 32'(0));

    // Queued TX word
    load_tx(0, 16'h3C);
    frame_begin(0);
    q0.push_back(16'hA5); spi_word(0, 8, 16'hA5, d); check_eq("miso_3c", 32'(d), 32'h3C);
    frame_end(0);
    check_eq("tx_ready_back", 32'(tx_ready0), 32'(1));

    // Overflow: five words into a four-deep FIFO with no pops
    rx_ready0 = 1'b0;
    frame_begin(0);
    for (int w = 1; w <= 5; w++) begin
      if (w <= 4) q0.push_back(16'(w));
      spi_word(0, 8, 16'(w), d);
      check_eq("ovf_miso", 32'(d), (w == 1) ? 32'hA5 : 32'(w - 1));
    end
    frame_end(0);
    check_eq("ovf_valid", 32'(rx_valid0), 32'(1));
    check_eq("ovf_head", 32'(rx_data0), 32'h01);
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    check_eq("ovr_set", 32'(ovr0), 32'(1));
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
    check_eq("ovr_clr", 32'(ovr0), 32'(0));
`endif
    rx_ready0 = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("ovf_drained", 32'(rx_valid0), 32'(0));

    // Partial word discarded, then a full word
    frame_begin(0); spi_word(0, 3, 16'h0005, d); frame_end(0);
    frame_begin(0);
    q0.push_back(16'hC3); spi_word(0, 8, 16'hC3, d); check_eq("partial_echo", 32'(d), 32'h05);
    frame_end(0);

    // Reset in the middle of a word
    rx_ready0 = 1'b0;
    frame_begin(0); q0.push_back(16'h11); spi_word(0, 8, 16'h11, d); frame_end(0);
    check_eq("pre_rst_valid", 32'(rx_valid0), 32'(1));
    frame_begin(0);
    load_tx(0, 16'h77);
    spi_word(0, 4, 16'h0009, d);
    rst = 1'b1; cs0_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_oe", 32'(miso_oe0), 32'(0));
    check_eq("rst_mid_valid", 32'(rx_valid0), 32'(0));
    check_eq("rst_mid_tx_ready", 32'(tx_ready0), 32'(1));
    rst = 1'b0;
    q0.delete();
    rx_ready0 = 1'b1;
    repeat (2 * HC) @(negedge clk);
    frame_begin(0);
    q0.push_back(16'h96); spi_word(0, 8, 16'h96, d); check_eq("post_rst_miso", 32'(d), 32'h00);
    frame_end(0);

    // CPOL=1/CPHA=1, 16-bit words
    load_tx(1, 16'h1234);
    frame_begin(1);
    q1.push_back(16'hBEEF); spi_word(1, 16, 16'hBEEF, d); check_eq("m3_miso", 32'(d), 32'h1234);
    q1.push_back(16'h0F0F); spi_word(1, 16, 16'h0F0F, d); check_eq("m3_echo", 32'(d), 32'hBEEF);
    frame_end(1);
    check_eq("m3_tx_ready", 32'(tx_ready1), 32'(1));

    repeat (20) @(negedge clk);
    check_eq("q0_left", 32'(q0.size()), 32'(0));
    check_eq("q1_left", 32'(q1.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
